data_store_buffer: RTL and testbench



---
 rtl/data_store_buffer.sv | 156 +++++++++++++++
 tb/tb_data_store_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_store_buffer.sv
// Posted-write store buffer between the core data port and a synchronous SRAM.
// Loads own the SRAM port except when a starving buffer forces one drain.
module data_store_buffer #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        buf_empty,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [29:0]   ent_addr_q [DEPTH];
    logic [3:0]    ent_wen_q  [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          load_pending_q, load_pending_d;
    logic [3:0]    fwd_mask_q, fwd_mask_d;
    logic [31:0]   fwd_data_q, fwd_data_d;

    logic          is_store, is_load, full, non_empty;
    logic          forced, load_acc, store_acc, drain;
    logic [PW-1:0] fwd_idx;

    assign is_store  = cpu_en && (cpu_wen != 4'b0000);
    assign is_load   = cpu_en && (cpu_wen == 4'b0000);
    assign full      = (count_q == CW'(DEPTH));
    assign non_empty = (count_q != '0);
    assign buf_empty = !non_empty;

    // A starved buffer steals exactly one load cycle; the load retries next cycle.
    assign forced    = is_load && non_empty && (starve_q == SW'(STARVE_MAX));
    assign load_acc  = is_load && !forced;
    assign store_acc = is_store && !full;
    assign drain     = non_empty && !load_acc;
    assign cpu_stall = (is_store && full) || forced;

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (load_acc) begin
            sram_en   = 1'b1;
            sram_addr = {cpu_addr[31:2], 2'b00};
        end else if (drain) begin
            sram_en    = 1'b1;
            sram_wen   = ent_wen_q[head_q];
            sram_addr  = {ent_addr_q[head_q], 2'b00};
            sram_wdata = ent_data_q[head_q];
        end
    end

    // Walk oldest to youngest so younger entries overwrite older lanes.
    // The head entry is still included when it drains this same cycle.
    always_comb begin
        fwd_mask_d = 4'b0000;
        fwd_data_d = 32'h0;
        fwd_idx    = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (ent_addr_q[fwd_idx] == cpu_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (ent_wen_q[fwd_idx][b]) begin
                        fwd_mask_d[b]          = 1'b1;
                        fwd_data_d[8*b +: 8]   = ent_data_q[fwd_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        starve_d       = starve_q;
        load_pending_d = load_acc;
        if (store_acc) begin
            tail_d = tail_q + PW'(1);
        end
        if (drain) begin
            head_d = head_q + PW'(1);
        end
        if (store_acc && !drain) begin
            count_d = count_q + CW'(1);
        end else if (drain && !store_acc) begin
            count_d = count_q - CW'(1);
        end
        if (drain || !non_empty) begin
            starve_d = '0;
        end else if (load_acc) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            starve_q       <= '0;
            load_pending_q <= 1'b0;
            fwd_mask_q     <= 4'b0000;
            fwd_data_q     <= 32'h0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            starve_q       <= starve_d;
            load_pending_q <= load_pending_d;
            if (load_acc) begin
                fwd_mask_q <= fwd_mask_d;
                fwd_data_q <= fwd_data_d;
            end
        end
    end

    // Entry storage needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            ent_addr_q[tail_q] <= cpu_addr[31:2];
            ent_wen_q[tail_q]  <= cpu_wen;
            ent_data_q[tail_q] <= cpu_wdata;
        end
    end

    always_comb begin
        cpu_rdata = 32'h0;
        if (load_pending_q) begin
            for (int b = 0; b < 4; b++) begin
                cpu_rdata[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8]
                                                    : sram_rdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_store_buffer.sv
// Self-checking bench for data_store_buffer: architectural memory model with
// load-result and SRAM-write scoreboards plus directed scenario checks.
module tb_data_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_en = 1'b0;
    logic [3:0]  cpu_wen = 4'b0000;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        buf_empty;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;

    data_store_buffer #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .buf_empty(buf_empty),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model; the preload port lets the bench seed contents from its own process.
    logic [31:0] smem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'h0;
    logic [31:0] pre_data = 32'h0;

    always @(posedge clk) begin
        if (pre_we) begin
            smem[pre_idx] <= pre_data;
        end else if (sram_en) begin
            if (sram_wen == 4'b0000) begin
                sram_rdata <= smem[sram_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b]) smem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    logic [31:0] amem [256];
    logic [31:0] rq [$];
    logic [67:0] wq [$];
    logic        pend_load = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic preload_word(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        amem[idx] = data;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic drive_cycle(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic stalled,
                               output logic [31:0] rdata);
        logic [31:0] exp;
        logic [67:0] wexp;
        @(negedge clk);
        cpu_en = en; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
        #4;
        stalled = cpu_stall;
        rdata   = cpu_rdata;
        n_checks++;
        if (pend_load) begin
            exp = rq.pop_front();
            if (cpu_rdata !== exp) begin
                n_fail++;
                $display("FAIL load_data: got %h expected %h", cpu_rdata, exp);
            end
        end else if (cpu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rdata_idle: got %h expected 00000000", cpu_rdata);
        end
        pend_load = 1'b0;
        if (sram_en === 1'b1 && sram_wen !== 4'b0000) begin
            n_checks++;
            if (wq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr %h wen %b data %h, expected none",
                         sram_addr, sram_wen, sram_wdata);
            end else begin
                wexp = wq.pop_front();
                if ({sram_addr, sram_wen, sram_wdata} !== wexp) begin
                    n_fail++;
                    $display("FAIL sram_write: got %h/%b/%h expected %h/%b/%h",
                             sram_addr, sram_wen, sram_wdata, wexp[67:36], wexp[35:32], wexp[31:0]);
                end
            end
        end
        if (en && wen == 4'b0000 && !stalled) begin
            rq.push_back(amem[addr[9:2]]);
            pend_load = 1'b1;
            n_checks++;
            if (sram_en !== 1'b1 || sram_wen !== 4'b0000 || sram_addr !== {addr[31:2], 2'b00}) begin
                n_fail++;
                $display("FAIL load_port: got en %b wen %b addr %h expected 1/0000/%h",
                         sram_en, sram_wen, sram_addr, {addr[31:2], 2'b00});
            end
        end
        if (en && wen != 4'b0000 && !stalled) begin
            for (int b = 0; b < 4; b++)
                if (wen[b]) amem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
            wq.push_back({addr[31:2], 2'b00, wen, wdata});
        end
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if (cpu_stall !== 1'b0 || buf_empty !== 1'b1 || sram_en !== 1'b0 || sram_wen !== 4'b0 ||
            sram_addr !== 32'h0 || sram_wdata !== 32'h0 || cpu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall %b empty %b en %b wen %b addr %h wd %h rd %h expected 0 1 0 0 0 0 0",
                     cpu_stall, buf_empty, sram_en, sram_wen, sram_addr, sram_wdata, cpu_rdata);
        end
        for (int i = 0; i < 256; i++)
            preload_word(8'(i), (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_drain;
        logic st; logic [31:0] rd;
        drive_cycle(1'b1, 4'b1111, 32'h10, 32'hAABBCCDD, st, rd);
        n_checks++;
        if (st !== 1'b0 || buf_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_store: got stall %b empty %b expected 0 1", st, buf_empty);
        end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
        n_checks++;
        if (sram_en !== 1'b1 || sram_wen !== 4'b1111 || sram_addr !== 32'h10 ||
            sram_wdata !== 32'hAABBCCDD || buf_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: got en %b wen %b addr %h data %h empty %b expected 1 1111 00000010 aabbccdd 0",
                     sram_en, sram_wen, sram_addr, sram_wdata, buf_empty);
        end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
        n_checks++;
        if (buf_empty !== 1'b1 || sram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after: got empty %b en %b expected 1 0", buf_empty, sram_en);
        end
    endtask

    task automatic test_back_to_back;
        logic st; logic [31:0] rd;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 4'b1111, 32'h40 + 32'(4 * i), $urandom, st, rd);
            n_checks++;
            if (st !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_stall_%0d: got %b expected 0", i, st);
            end
        end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
        n_checks++;
        if (buf_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_empty: got %b expected 1", buf_empty);
        end
    endtask

    task automatic test_fwd_partial;
        logic st; logic [31:0] rd;
        preload_word(8'h08, 32'h55667788);
        drive_cycle(1'b1, 4'b0011, 32'h20, 32'h00001122, st, rd);
        drive_cycle(1'b1, 4'b0000, 32'h20, 32'h0, st, rd);
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
        n_checks++;
        if (rd !== 32'h55661122) begin
            n_fail++;
            $display("FAIL fwd_partial: got %h expected 55661122", rd);
        end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
    endtask

    task automatic test_fwd_overlap;
        logic st; logic [31:0] rd;
        drive_cycle(1'b1, 4'b1111, 32'h30, 32'h11111111, st, rd);
        drive_cycle(1'b1, 4'b0001, 32'h30, 32'h000000FF, st, rd);
        drive_cycle(1'b1, 4'b0000, 32'h30, 32'h0, st, rd);
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
        n_checks++;
        if (rd !== 32'h111111FF) begin
            n_fail++;
            $display("FAIL fwd_overlap: got %h expected 111111ff", rd);
        end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
    endtask

    task automatic test_starvation;
        logic st; logic [31:0] rd;
        drive_cycle(1'b1, 4'b1111, 32'h60, 32'hDEADBEEF, st, rd);
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 4'b0000, 32'h70, 32'h0, st, rd);
            n_checks++;
            if (st !== 1'b0 || buf_empty !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_load_%0d: got stall %b empty %b expected 0 0", i, st, buf_empty);
            end
        end
        drive_cycle(1'b1, 4'b0000, 32'h70, 32'h0, st, rd);
        n_checks++;
        if (st !== 1'b1 || sram_wen !== 4'b1111 || sram_addr !== 32'h60) begin
            n_fail++;
            $display("FAIL starve_forced: got stall %b wen %b addr %h expected 1 1111 00000060",
                     st, sram_wen, sram_addr);
        end
        drive_cycle(1'b1, 4'b0000, 32'h70, 32'h0, st, rd);
        n_checks++;
        if (st !== 1'b0 || buf_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_retry: got stall %b empty %b expected 0 1", st, buf_empty);
        end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
    endtask

    task automatic test_reset_midstream;
        logic st; logic [31:0] rd;
        logic [31:0] old;
        old = amem[8'h20];
        drive_cycle(1'b1, 4'b1111, 32'h80, 32'h12345678, st, rd);
        drive_cycle(1'b1, 4'b0000, 32'h84, 32'h0, st, rd);
        @(negedge clk);
        cpu_en = 1'b0; cpu_wen = 4'b0000; rst = 1'b1;
        #1;
        n_checks++;
        if (cpu_stall !== 1'b0 || buf_empty !== 1'b1 || sram_en !== 1'b0 || sram_wen !== 4'b0 ||
            sram_addr !== 32'h0 || sram_wdata !== 32'h0 || cpu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got stall %b empty %b en %b wen %b addr %h wd %h rd %h expected 0 1 0 0 0 0 0",
                     cpu_stall, buf_empty, sram_en, sram_wen, sram_addr, sram_wdata, cpu_rdata);
        end
        pend_load = 1'b0;
        rq.delete();
        wq.delete();
        amem[8'h20] = old;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
        drive_cycle(1'b1, 4'b0000, 32'h80, 32'h0, st, rd);
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
        n_checks++;
        if (rd !== old) begin
            n_fail++;
            $display("FAIL midreset_lost: got %h expected %h", rd, old);
        end
    endtask

    task automatic test_random;
        logic st; logic [31:0] rd;
        logic [3:0] w;
        int r;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 3);
            w = 4'($urandom_range(1, 15));
            if (r == 0)
                drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
            else if (r == 1)
                drive_cycle(1'b1, 4'b0000, 32'hC0 + 32'(4 * $urandom_range(0, 3)), 32'h0, st, rd);
            else
                drive_cycle(1'b1, w, 32'hC0 + 32'(4 * $urandom_range(0, 3)), $urandom, st, rd);
        end
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0, st, rd);
        n_checks++;
        if (buf_empty !== 1'b1 || wq.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got empty %b pending writes %0d expected 1 0", buf_empty, wq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_back_to_back();
        test_fwd_partial();
        test_fwd_overlap();
        test_starvation();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
